// File: rtl/fp_meter.sv
// Frequency/period meter: synchronises an asynchronous divided clock or pulse
// and reports period, high time, timeout and (with FP_METER_LOCK_EN) lock.
module fp_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout,
  output logic             locked
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sync;
  logic                   rise;
  logic                   fall;

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge value of its neighbours; a blocking = here would collapse
  // the synchroniser chain into a single stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~hist_q;
  assign fall = ~sync & hist_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             open_q, open_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    hcnt_d    = hcnt_q;
    open_d    = open_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    case (state_q)
      IDLE: begin
        pcnt_d = '0;
        hcnt_d = '0;
        open_d = 1'b0;
        if (rise) begin
          pcnt_d  = CNT_ONE;
          hcnt_d  = CNT_ONE;
          open_d  = 1'b1;
          state_d = MEAS;
        end
      end
      MEAS: begin
        if (rise) begin
          period_d  = pcnt_q;
          high_d    = hcnt_q;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          pcnt_d    = CNT_ONE;
          hcnt_d    = CNT_ONE;
          open_d    = 1'b1;
        end else if (pcnt_q == CNT_MAX) begin
          // Input stalled: give up on this period, keep the last result.
          timeout_d = 1'b1;
          pcnt_d    = '0;
          hcnt_d    = '0;
          open_d    = 1'b0;
          state_d   = IDLE;
        end else begin
          pcnt_d = pcnt_q + CNT_ONE;
          if (fall) begin
            open_d = 1'b0;
          end else if (open_q) begin
            hcnt_d = hcnt_q + CNT_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      hcnt_q    <= '0;
      open_q    <= 1'b0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      hcnt_q    <= hcnt_d;
      open_q    <= open_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = valid_q;
  assign timeout    = timeout_q;

`ifdef FP_METER_LOCK_EN
  logic [CNT_W-1:0] prev_q;
  logic             locked_q;

  // prev_q is cleared on timeout so the first period after IDLE can never lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= '0;
      locked_q <= 1'b0;
    end else if (state_q == MEAS && state_d == IDLE) begin
      prev_q   <= '0;
      locked_q <= 1'b0;
    end else if (valid_d) begin
      prev_q   <= pcnt_q;
      locked_q <= (pcnt_q == prev_q);
    end
  end

  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_fp_meter.sv
// Scoreboard bench for fp_meter: an edge-time model predicts each measurement,
// a monitor pops and compares on every meas_valid; a 4-bit instance covers timeout.
module tb_fp_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sig = 1'b0;
  logic        sig_s = 1'b0;

  logic [15:0] period, high_time;
  logic        meas_valid, timeout, locked;
  logic [3:0]  s_period, s_high;
  logic        s_valid, s_timeout, s_locked;

  fp_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .locked     (locked)
  );

  fp_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut_s (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_s),
    .period     (s_period),
    .high_time  (s_high),
    .meas_valid (s_valid),
    .timeout    (s_timeout),
    .locked     (s_locked)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a measurement is simply the distance between consecutive
  // rising edges of the driven signal, with the falling edge in between.
  typedef struct {
    int   per;
    int   hi;
    logic lk;
  } exp_t;

  exp_t q[$];
  int   last_rise, last_fall, prev_per;
  bit   have_rise;

  task automatic model_reset();
    have_rise = 1'b0;
    prev_per  = 0;
  endtask

  task automatic model_rise();
    exp_t e;
    if (have_rise) begin
      e.per = cyc - last_rise;
      e.hi  = last_fall - last_rise;
`ifdef FP_METER_LOCK_EN
      e.lk  = (e.per == prev_per);
`else
      e.lk  = 1'b0;
`endif
      q.push_back(e);
      prev_per = e.per;
    end
    have_rise = 1'b1;
    last_rise = cyc;
  endtask

  // Inputs change right after a falling clock edge and hold for n cycles.
  task automatic drive(input bit v, input int n);
    sig = v;
    if (v) model_rise();
    else last_fall = cyc;
    repeat (n) @(negedge clk);
  endtask

  task automatic seg(input int h, input int l);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drain", q.size(), 0);
  endtask

  // Monitor: decoupled from stimulus, compares whatever the DUT presents.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && meas_valid) begin
      if (q.size() == 0) begin
        check("unexpected_meas_valid", meas_valid, 1'b0);
      end else begin
        e = q.pop_front();
        check("period", period, e.per);
        check("high_time", high_time, e.hi);
        check("locked", locked, e.lk);
        check("timeout_during_meas", timeout, 1'b0);
      end
    end
  end

  int sm_pulses;

  task automatic drive_s(input bit v, input int n);
    sig_s = v;
    repeat (n) begin
      @(negedge clk);
      if (s_valid) sm_pulses++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit found;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_period", period, 0);
    check("rst_high_time", high_time, 0);
    check("rst_meas_valid", meas_valid, 0);
    check("rst_timeout", timeout, 0);
    check("rst_locked", locked, 0);
    check("rst_s_period", s_period, 0);
    check("rst_s_timeout", s_timeout, 0);
    rst = 1'b0;
    @(negedge clk);

    repeat (5) seg(8, 8);      // divide-by-16
    repeat (6) seg(1, 1);      // toggle every clk
    repeat (3) seg(3, 7);      // 3 high, 7 low
    seg(4, 4);                 // periods 8, 8, 12 for lock
    seg(4, 4);
    seg(6, 6);
    repeat (40) seg(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)));
    repeat (3) seg(4, 4);      // divide-by-8, then reset mid-period
    drive(1'b1, 4);
    drive(1'b0, 2);
    wait_drain();

    rst = 1'b1;
    #1;
    check("midrst_period", period, 0);
    check("midrst_high_time", high_time, 0);
    check("midrst_meas_valid", meas_valid, 0);
    check("midrst_timeout", timeout, 0);
    check("midrst_locked", locked, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    repeat (3) seg(4, 4);
    drive(1'b1, 2);
    drive(1'b0, 2);
    wait_drain();

    // Timeout on the 4-bit instance: max count 15.
    sm_pulses = 0;
    drive_s(1'b1, 3);
    drive_s(1'b0, 3);
    check("s_no_meas_on_first_rise", sm_pulses, 0);
    sig_s = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (s_valid) sm_pulses++;
      if (k == 17) check("s_timeout_not_early", s_timeout, 0);
    end
    check("s_timeout_set", s_timeout, 1);
    check("s_meas_count", sm_pulses, 1);
    check("s_period_kept", s_period, 6);
    check("s_high_kept", s_high, 3);
    check("s_locked_first", s_locked, 0);

    sm_pulses = 0;
    drive_s(1'b0, 2);
    drive_s(1'b1, 2);
    drive_s(1'b0, 3);
    check("s_no_meas_after_timeout_rise", sm_pulses, 0);
    check("s_timeout_sticky", s_timeout, 1);
    sig_s = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (s_valid) found = 1'b1;
    end
    check("s_meas_after_timeout", found, 1);
    check("s_period_fresh", s_period, 5);
    check("s_high_fresh", s_high, 2);
    check("s_timeout_cleared", s_timeout, 0);
    check("s_locked_fresh", s_locked, 0);
    sig_s = 1'b0;
    repeat (4) @(negedge clk);

    wait_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_meter.md
# fp_meter

Frequency/period meter: the measuring end of the team's clock dividers. Takes an asynchronous divided-clock or pulse signal, synchronises it into `clk`, and reports the period and high time of every input cycle in `clk` cycles, with a one-cycle valid strobe. It also reports timeout (input stalled) and, optionally, lock (period stable). It sits beside the divider blocks as a self-check and bring-up monitor.

## Interface
- `CNT_W`, default 16: width of the period and high-time counters and outputs.
- `SYNC_STAGES`, default 2: number of flip-flops in the input synchroniser (minimum 2).

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `sig_in`  in  1  measured signal, asynchronous to `clk`.
- `period`  out  CNT_W  clk cycles between the last two rising edges.
- `high_time`  out  CNT_W  clk cycles `sig_in` was high within the last completed period.
- `meas_valid`  out  1  one-cycle strobe: `period` and `high_time` were just updated.
- `timeout`  out  1  sticky flag: no rising edge within 2^CNT_W−1 cycles.
- `locked`  out  1  the last two measured periods were equal (see Configuration).

## Operation
- Synchroniser: `SYNC_STAGES` flops, then one history flop. `rise` = sync & ~hist; `fall` = ~sync & hist. `rise` and `fall` are never both asserted.
- Counters: `pcnt` and `hcnt`, CNT_W bits each.
- FSM states:
  - IDLE (reset state): counters held at 0. On `rise`: `pcnt`<=1, `hcnt`<=1, go to MEAS. No measurement is produced.
  - MEAS:
    - `pcnt` increments every cycle.
    - `hcnt` increments while the high phase is open. The high phase opens on `rise` and closes on `fall`.
    - On `rise`: `period`<=`pcnt`, `high_time`<=`hcnt`, pulse `meas_valid`, clear `timeout`, reload `pcnt`<=1 and `hcnt`<=1, and stay in MEAS.
    - If `pcnt` reaches 2^CNT_W−1 with no `rise`: set `timeout`=1, clear `locked`, go to IDLE. `period` and `high_time` keep their previous values.
- `fall` in IDLE is ignored.
- A high phase still open at the next `rise` is impossible after synchronisation. No special case is needed.
- Widths: counters saturate only through the timeout path. They never wrap.

## Timing
- Reset values: `period`=0, `high_time`=0, `meas_valid`=0, `timeout`=0, `locked`=0, FSM=IDLE, synchroniser flops=0.
- `rst` asserted mid-measurement clears all of the above immediately (asynchronously). The first measurement after reset needs two `rise` events.
- Latency:
  - `sig_in` edge to internal `rise`/`fall`: SYNC_STAGES+1 clk cycles.
  - `rise` to `meas_valid`: 1 cycle, with outputs registered in the same cycle.
- `meas_valid` is high for exactly one cycle per measured period. It is never asserted in IDLE.
- Minimum measurable input: period 2, high time 1 (toggle every `clk`).
- Sampling uncertainty: ±1 count per edge for truly asynchronous inputs.

## Configuration
- `FP_METER_LOCK_EN` defined:
  - A register holds the previous `period`.
  - On each `meas_valid`, `locked`<=1 if the new period equals the previous one, else `locked`<=0.
  - The first measurement after IDLE compares against 0 and so cannot set `locked`.
  - Timeout and reset clear `locked`.
- `FP_METER_LOCK_EN` undefined: the compare logic and the previous-period register are absent, and `locked` is tied to 0.

## Test plan
- Synchronous `sig_in` from a divide-by-16 (8 high, 8 low), run for 4 periods -> from the second rise on, `meas_valid` pulses every 16 cycles with `period`=16 and `high_time`=8.
- `sig_in` toggling every `clk` -> `period`=2, `high_time`=1, `meas_valid` every 2 cycles.
- CNT_W=4: one rise, then `sig_in` held high -> `timeout`=1 exactly 15 cycles after the internal rise, FSM in IDLE, outputs unchanged. A new rise pair then clears `timeout` and reports a fresh `period`.
- `FP_METER_LOCK_EN`: periods 8, 8, 12 -> `locked` goes 0, 1, 0 across the three `meas_valid` strobes. With the macro undefined, `locked` stays 0 throughout.
- `rst` pulsed mid-period (divide-by-8 input) -> all outputs 0 within the reset cycle. The first `meas_valid` after reset comes at the second rise, with `period`=8.
- Divide-by-10 input with 3 high, 7 low -> `period`=10, `high_time`=3. No `meas_valid` is produced by falling edges.
